vga_scanout: RTL



---
 rtl/vga_scanout.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// Parametrised VGA scanout: H/V timing, framebuffer address generation with 2^SCALE_SHIFT
// pixel replication, VRAM latency compensation. Optional VGA_DOUBLE_BUF_EN adds buf_sel.
module vga_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int SCALE_SHIFT = 0,
  parameter int RD_LATENCY  = 1,
  parameter int ADDR_W      = 19,
  parameter int PIX_W       = 12
) (
  input  logic              vga_clk,
  input  logic              clrn,
`ifdef VGA_DOUBLE_BUF_EN
  input  logic              buf_sel,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [3:0]        r,
  output logic [3:0]        g,
  output logic [3:0]        b,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H    = V_ACTIVE >> SCALE_SHIFT;
  localparam int BUF_OFF = FB_W * FB_H;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  // One extra bit so a sync window ending exactly at the total cannot wrap.
  localparam logic [HW:0]   H_ACT  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   H_SS   = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   H_SE   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   V_ACT  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   V_SS   = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   V_SE   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (((H_ACTIVE >> SCALE_SHIFT) << SCALE_SHIFT) != H_ACTIVE ||
      ((V_ACTIVE >> SCALE_SHIFT) << SCALE_SHIFT) != V_ACTIVE || RD_LATENCY < 1) begin : g_bad_cfg
    $error("vga_scanout: active size not divisible by 2**SCALE_SHIFT, or RD_LATENCY < 1");
  end

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [HW:0]       h_ext;
  logic [VW:0]       v_ext;
  logic              active;
  logic              hs_raw;
  logic              vs_raw;
  logic              first_px;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] v_term;
  logic [ADDR_W-1:0] h_term;
  logic [ADDR_W-1:0] addr_next;

  // Flag pipeline: RD_LATENCY+1 stages here, the output registers form the last stage.
  logic [RD_LATENCY:0] act_p;
  logic [RD_LATENCY:0] hs_p;
  logic [RD_LATENCY:0] vs_p;
  logic [RD_LATENCY:0] fs_p;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign h_ext    = {1'b0, h_cnt};
  assign v_ext    = {1'b0, v_cnt};
  assign active   = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign hs_raw   = (h_ext >= H_SS) && (h_ext < H_SE);
  assign vs_raw   = (v_ext >= V_SS) && (v_ext < V_SE);
  assign first_px = (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_DOUBLE_BUF_EN
  logic latched_sel;

  // Buffer choice only moves on the final clock of a frame, so a frame never tears.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      latched_sel <= 1'b0;
    end else if (h_cnt == H_LAST && v_cnt == V_LAST) begin
      latched_sel <= buf_sel;
    end
  end

  assign base = latched_sel ? ADDR_W'(BUF_OFF) : '0;
`else
  assign base = '0;
`endif

  assign v_term    = ADDR_W'(32'(v_cnt >> SCALE_SHIFT) * FB_W);
  assign h_term    = ADDR_W'(h_cnt >> SCALE_SHIFT);
  assign addr_next = base + v_term + h_term;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= active;
      if (active) begin
        rd_addr <= addr_next;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      act_p       <= '0;
      hs_p        <= '0;
      vs_p        <= '0;
      fs_p        <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      act_p       <= {act_p[RD_LATENCY-1:0], active};
      hs_p        <= {hs_p[RD_LATENCY-1:0], hs_raw};
      vs_p        <= {vs_p[RD_LATENCY-1:0], vs_raw};
      fs_p        <= {fs_p[RD_LATENCY-1:0], first_px};
      de          <= act_p[RD_LATENCY];
      frame_start <= fs_p[RD_LATENCY];
      hs          <= hs_p[RD_LATENCY] ? SYNC_POL : ~SYNC_POL;
      vs          <= vs_p[RD_LATENCY] ? SYNC_POL : ~SYNC_POL;
      if (act_p[RD_LATENCY]) begin
        r <= rd_data[11:8];
        g <= rd_data[7:4];
        b <= rd_data[3:0];
      end else begin
        r <= '0;
        g <= '0;
        b <= '0;
      end
    end
  end

endmodule
